instr_enc: RTL and testbench
============================

// Module: instr_enc
// PURPOSE
//  Instruction encoder: packs decoded MSP430 fields into 1-3 ROM words (opcode, src ext, dst ext).
//  Writes them sequentially onto the MAB/MDB write port. Builds and loads program ROM images for
//  fetch-side test benches and the boot loader; bit-exact inverse of the instruction decoder.
// PARAMETERS
//  ORIGIN     16'hC000  address of first word after reset
//  ADDR_STEP  2         byte increment between words
// PORTS
//  clk         in   1   sole clock; all state on posedge
//  rst         in   1   synchronous, active-high reset
//  in_valid    in   1   instruction fields valid
//  in_ready    out  1   encoder idle, can accept
//  in_fmt      in   2   1=FMT_I, 2=FMT_II, 3=FMT_J, 0=illegal
//  in_op       in   4   FMT_I opcode [15:12]; FMT_II/J use [2:0] (op / condition)
//  in_src      in   4   source reg (FMT_II: the operand reg)
//  in_dst      in   4   destination reg (FMT_I only)
//  in_as       in   2   As;  in_ad in 1 Ad;  in_bw in 1 byte/word
//  in_src_ext  in   16  source extension word / immediate
//  in_dst_ext  in   16  destination extension word
//  in_jmp_off  in   10  signed word offset (FMT_J)
//  ld_addr     in   1   load write address from ld_val (honoured in IDLE only)
//  ld_val      in   16  new write address
//  MAB_out     out  16  write address;  MDB_in out 16 write data
//  MW          out  1   memory write strobe
//  mem_ready   in   1   ROM accepts word this cycle when MW && mem_ready
//  done        out  1   1-cycle pulse after last word accepted
//  err         out  1   1-cycle pulse: illegal instruction rejected
//  addr_wrap   out  1   sticky: address wrapped 16'hFFFE->0; cleared by rst/ld_addr
// BEHAVIOUR
//  Reset: state IDLE, MAB_out=ORIGIN, MDB_in=0, MW=0, done=0, err=0, addr_wrap=0; in_ready=0 while rst high.
//  FSM IDLE -> OPC -> [SRC_EXT] -> [DST_EXT] -> IDLE; in_ready = (state==IDLE).
//  Accept on in_valid&&in_ready; fields latched; MW=1 with opcode word next cycle.
//  Each word held (MAB_out, MDB_in, MW) until mem_ready; then MAB_out+=ADDR_STEP, next state.
//  Address increment is mod 2^16; crossing to 0 sets addr_wrap.
//  Last word accepted -> IDLE, MW=0, done=1 same cycle as IDLE entry; one bubble between instrs.
//  FMT_I word {op,src,ad,bw,as,dst}; FMT_II {6'b000100,op[2:0],bw,as,src}; FMT_J {3'b001,op[2:0],off}.
//  src ext needed: (as==01 && src!=3) || (as==11 && src==0); FMT_J never.
//  dst ext needed: FMT_I && ad==1. Order: opcode, src ext, dst ext.
//  Illegal: fmt==0, FMT_I op<4, FMT_II op==7 -> accepted, err=1 next cycle, no MW, stay IDLE.
//  ld_addr with accept in same IDLE cycle: load first, instruction written from ld_val.
//  ld_addr outside IDLE ignored. in_* ignored outside IDLE.
//  rst mid-instruction: abort; MW=0 next cycle, remaining words dropped, MAB_out=ORIGIN.
// CONFIGURATION
//  INSTR_ENC_CG_EN: immediate source (FMT_I/II, src==0, as==11) mapped to constant generator.
//  Immediates 0/1/2/-1 -> src=3, as=00/01/10/11. Immediates 4/8 -> src=2, as=10/11.
//  -1 matches 16'hFFFF (bw=0) or low byte 8'hFF (bw=1). Mapped instructions drop the src ext word.
//  Undefined: every immediate emits an extension word as given.
// TESTING
//  1 ORIGIN C000, MOV R5,R6 (fmt1 op4 src5 dst6 as0 ad0 bw0) -> 4506@C000; done; next addr C002.
//  2 ADD #1234,&0200 (op5 src0 as3 dst2 ad1) -> 50B2@C000, 1234@C002, 0200@C004; done after 3rd.
//  3 Case 2 with mem_ready=0 three cycles on word 2 -> MAB_out=C002, MDB_in=1234, MW=1 held; no skip.
//  4 MOV #1,R4 (op4 src0 as3 ext 0001) -> undefined CG_EN: 4034,0001; defined: single word 4314.
//  5 JNE -3 (fmt3 op0 off 3FD) -> 23FD. RRA R7 (fmt2 op2 src7) -> 1107. fmt0 -> err pulse, MW=0.
//  6 ld_val FFFE then case 2 -> words at FFFE,0000,0002; addr_wrap=1.
//    rst during word 2 -> MW=0 next cycle, MAB_out=C000.

Source files
------------

// File: rtl/instr_enc.sv
// MSP430 instruction encoder: 1-3 words out on MAB/MDB; INSTR_ENC_CG_EN maps immediates to the constant generator.
// First word is on the bus the cycle after accept; each word is held until mem_ready; in_ready only in IDLE.
module instr_enc #(
  parameter logic [15:0] ORIGIN    = 16'hC000,
  parameter int          ADDR_STEP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [3:0]  in_op,
  input  logic [3:0]  in_src,
  input  logic [3:0]  in_dst,
  input  logic [1:0]  in_as,
  input  logic        in_ad,
  input  logic        in_bw,
  input  logic [15:0] in_src_ext,
  input  logic [15:0] in_dst_ext,
  input  logic [9:0]  in_jmp_off,
  input  logic        ld_addr,
  input  logic [15:0] ld_val,
  output logic [15:0] MAB_out,
  output logic [15:0] MDB_in,
  output logic        MW,
  input  logic        mem_ready,
  output logic        done,
  output logic        err,
  output logic        addr_wrap
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OPC  = 2'd1;
  localparam logic [1:0] S_SRC  = 2'd2;
  localparam logic [1:0] S_DST  = 2'd3;

  logic [1:0]  state;
  logic [15:0] src_ext_q, dst_ext_q;
  logic        need_src_q, need_dst_q;

  logic [3:0]  src_eff;
  logic [1:0]  as_eff;
  logic        need_src, need_dst, illegal;
  logic [15:0] opc_word;
  logic [16:0] addr_sum;

  always_comb begin
    src_eff = in_src;
    as_eff  = in_as;
`ifdef INSTR_ENC_CG_EN
    // A remapped immediate no longer satisfies the src-ext condition, so its ext word drops out naturally.
    if ((in_fmt == 2'd1 || in_fmt == 2'd2) && in_src == 4'd0 && in_as == 2'b11) begin
      if (in_src_ext == 16'h0000) begin
        src_eff = 4'd3; as_eff = 2'b00;
      end else if (in_src_ext == 16'h0001) begin
        src_eff = 4'd3; as_eff = 2'b01;
      end else if (in_src_ext == 16'h0002) begin
        src_eff = 4'd3; as_eff = 2'b10;
      end else if (in_src_ext == 16'hFFFF || (in_bw && in_src_ext[7:0] == 8'hFF)) begin
        src_eff = 4'd3; as_eff = 2'b11;
      end else if (in_src_ext == 16'h0004) begin
        src_eff = 4'd2; as_eff = 2'b10;
      end else if (in_src_ext == 16'h0008) begin
        src_eff = 4'd2; as_eff = 2'b11;
      end
    end
`endif
  end

  always_comb begin
    need_src = (in_fmt != 2'd3) &&
               ((as_eff == 2'b01 && src_eff != 4'd3) || (as_eff == 2'b11 && src_eff == 4'd0));
    need_dst = (in_fmt == 2'd1) && in_ad;
    illegal  = (in_fmt == 2'd0) || (in_fmt == 2'd1 && in_op < 4'd4) ||
               (in_fmt == 2'd2 && in_op[2:0] == 3'd7);
    case (in_fmt)
      2'd1:    opc_word = {in_op, src_eff, in_ad, in_bw, as_eff, in_dst};
      2'd2:    opc_word = {6'b000100, in_op[2:0], in_bw, as_eff, src_eff};
      2'd3:    opc_word = {3'b001, in_op[2:0], in_jmp_off};
      default: opc_word = 16'h0000;
    endcase
  end

  assign in_ready = (state == S_IDLE) && !rst;
  assign addr_sum = {1'b0, MAB_out} + 17'(ADDR_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      MAB_out    <= ORIGIN;
      MDB_in     <= 16'h0000;
      MW         <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      addr_wrap  <= 1'b0;
      src_ext_q  <= 16'h0000;
      dst_ext_q  <= 16'h0000;
      need_src_q <= 1'b0;
      need_dst_q <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == S_IDLE) begin
        // Load takes effect before the accepted instruction is placed, so it is written at ld_val.
        if (ld_addr) begin
          MAB_out   <= ld_val;
          addr_wrap <= 1'b0;
        end
        if (in_valid) begin
          if (illegal) begin
            err <= 1'b1;
          end else begin
            state      <= S_OPC;
            MW         <= 1'b1;
            MDB_in     <= opc_word;
            src_ext_q  <= in_src_ext;
            dst_ext_q  <= in_dst_ext;
            need_src_q <= need_src;
            need_dst_q <= need_dst;
          end
        end
      end else if (MW && mem_ready) begin
        MAB_out <= addr_sum[15:0];
        if (addr_sum[16]) addr_wrap <= 1'b1;
        if (state == S_OPC && need_src_q) begin
          state  <= S_SRC;
          MDB_in <= src_ext_q;
        end else if (state != S_DST && need_dst_q) begin
          state  <= S_DST;
          MDB_in <= dst_ext_q;
        end else begin
          state <= S_IDLE;
          MW    <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_enc.sv
// Randomized bench for instr_enc against a word-list reference model of the encoding rules.
module tb_instr_enc;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_ad, in_bw, ld_addr, MW, mem_ready, done, err, addr_wrap;
  logic [1:0]  in_fmt, in_as;
  logic [3:0]  in_op, in_src, in_dst;
  logic [15:0] in_src_ext, in_dst_ext, ld_val, MAB_out, MDB_in;
  logic [9:0]  in_jmp_off;

  always #5 clk = ~clk;

  instr_enc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_op(in_op), .in_src(in_src), .in_dst(in_dst), .in_as(in_as), .in_ad(in_ad),
    .in_bw(in_bw), .in_src_ext(in_src_ext), .in_dst_ext(in_dst_ext), .in_jmp_off(in_jmp_off),
    .ld_addr(ld_addr), .ld_val(ld_val), .MAB_out(MAB_out), .MDB_in(MDB_in), .MW(MW),
    .mem_ready(mem_ready), .done(done), .err(err), .addr_wrap(addr_wrap)
  );

  typedef struct {
    int fmt, op, src, dst, as_, ad, bw, sext, dext, off;
  } instr_t;

  int n_checks = 0;
  int n_errors = 0;
  int model_addr;
  bit model_wrap;
  int exp_dat[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic instr_t mk(input int fmt, op, src, dst, as_, ad, bw, sext, dext, off);
    instr_t i;
    i.fmt = fmt; i.op = op; i.src = src; i.dst = dst; i.as_ = as_;
    i.ad = ad; i.bw = bw; i.sext = sext; i.dext = dext; i.off = off;
    return i;
  endfunction

  // Expected word list straight from the encoding rules; n=0 means the instruction is illegal.
  task automatic model_words(input instr_t i, output int n);
    int src, as_;
    src = i.src;
    as_ = i.as_;
    n = 0;
    if (i.fmt == 0 || (i.fmt == 1 && i.op < 4) || (i.fmt == 2 && i.op == 7)) return;
`ifdef INSTR_ENC_CG_EN
    if (i.fmt != 3 && src == 0 && as_ == 3) begin
      if (i.sext == 0) begin src = 3; as_ = 0; end
      else if (i.sext == 1) begin src = 3; as_ = 1; end
      else if (i.sext == 2) begin src = 3; as_ = 2; end
      else if (i.sext == 65535 || (i.bw == 1 && i.sext % 256 == 255)) begin src = 3; as_ = 3; end
      else if (i.sext == 4) begin src = 2; as_ = 2; end
      else if (i.sext == 8) begin src = 2; as_ = 3; end
    end
`endif
    case (i.fmt)
      1:       exp_dat[0] = i.op * 4096 + src * 256 + i.ad * 128 + i.bw * 64 + as_ * 16 + i.dst;
      2:       exp_dat[0] = 4096 + i.op * 128 + i.bw * 64 + as_ * 16 + src;
      default: exp_dat[0] = 8192 + i.op * 1024 + i.off;
    endcase
    n = 1;
    if (i.fmt != 3 && ((as_ == 1 && src != 3) || (as_ == 3 && src == 0))) begin
      exp_dat[n] = i.sext;
      n++;
    end
    if (i.fmt == 1 && i.ad == 1) begin
      exp_dat[n] = i.dext;
      n++;
    end
  endtask

  task automatic drive(input instr_t i);
    in_fmt = 2'(i.fmt); in_op = 4'(i.op); in_src = 4'(i.src); in_dst = 4'(i.dst);
    in_as = 2'(i.as_); in_ad = 1'(i.ad); in_bw = 1'(i.bw);
    in_src_ext = 16'(i.sext); in_dst_ext = 16'(i.dext); in_jmp_off = 10'(i.off);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after done (or err).
  task automatic run_instr(input instr_t i, input bit ld, input int ldv, input int stall_pct,
                           input int stall_word);
    int n, widx, hold, cycles;
    check("idle_ready", in_ready, 1);
    drive(i);
    in_valid = 1'b1;
    ld_addr = ld;
    ld_val = 16'(ldv);
    mem_ready = 1'($urandom_range(1));
    if (ld) begin
      model_addr = ldv;
      model_wrap = 1'b0;
    end
    model_words(i, n);
    @(negedge clk);
    in_valid = 1'b0;
    ld_addr = 1'b0;
    if (n == 0) begin
      check("err_pulse", err, 1);
      check("err_no_mw", MW, 0);
      check("err_idle", in_ready, 1);
      check("err_addr", MAB_out, model_addr);
      return;
    end
    check("no_err", err, 0);
    widx = 0; hold = 0; cycles = 0;
    while (widx < n && cycles < 100) begin
      check("mw", MW, 1);
      check("mab", MAB_out, model_addr);
      check("mdb", MDB_in, exp_dat[widx]);
      check("busy", in_ready, 0);
      check("no_done", done, 0);
      in_valid = 1'($urandom_range(1));
      ld_addr = 1'($urandom_range(1));
      ld_val = 16'($urandom);
      if (widx == stall_word && hold < 3) begin
        mem_ready = 1'b0;
        hold++;
      end else begin
        mem_ready = ($urandom_range(99) >= 32'(stall_pct));
      end
      if (mem_ready) begin
        widx++;
        if (model_addr + 2 > 65535) model_wrap = 1'b1;
        model_addr = (model_addr + 2) % 65536;
      end
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    ld_addr = 1'b0;
    check("timeout", cycles < 100, 1);
    check("done", done, 1);
    check("mw_low", MW, 0);
    check("ready_back", in_ready, 1);
    check("next_addr", MAB_out, model_addr);
    check("wrap", addr_wrap, model_wrap);
  endtask

  instr_t add_abs;
  instr_t ri;

  initial begin
    rst = 1'b1; in_valid = 1'b0; ld_addr = 1'b0; ld_val = 16'h0; mem_ready = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_mab", MAB_out, 16'hC000);
    check("rst_mdb", MDB_in, 0);
    check("rst_mw", MW, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wrap", addr_wrap, 0);
    rst = 1'b0;
    @(negedge clk);
    model_addr = 16'hC000;
    model_wrap = 1'b0;

    add_abs = mk(1, 5, 0, 2, 3, 1, 0, 16'h1234, 16'h0200, 0);
    run_instr(mk(1, 4, 5, 6, 0, 0, 0, 0, 0, 0), 0, 0, 0, -1);        // MOV R5,R6
    run_instr(add_abs, 1, 16'hC000, 0, -1);                           // ADD #1234,&0200
    run_instr(add_abs, 1, 16'hC000, 0, 1);                            // stall on word 2
    run_instr(mk(1, 4, 0, 4, 3, 0, 0, 1, 0, 0), 1, 16'hC000, 20, -1); // MOV #1,R4
    run_instr(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 10'h3FD), 0, 0, 20, -1);  // JNE -3
    run_instr(mk(2, 2, 7, 0, 0, 0, 0, 0, 0, 0), 0, 0, 20, -1);        // RRA R7
    run_instr(mk(0, 4, 5, 6, 0, 0, 0, 0, 0, 0), 0, 0, 0, -1);         // illegal fmt
    run_instr(mk(1, 3, 5, 6, 0, 0, 0, 0, 0, 0), 0, 0, 0, -1);         // illegal FMT_I op
    run_instr(mk(2, 7, 5, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, -1);         // illegal FMT_II op
    run_instr(add_abs, 1, 16'hFFFE, 30, -1);                          // wraps to 0

    ld_addr = 1'b1;
    ld_val = 16'hC000;
    @(negedge clk);
    ld_addr = 1'b0;
    check("ld_clears_wrap", addr_wrap, 0);
    check("ld_mab", MAB_out, 16'hC000);
    model_addr = 16'hC000;
    model_wrap = 1'b0;

    drive(add_abs);
    in_valid = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_mw", MW, 1);
    check("pre_rst_mab", MAB_out, 16'hC002);
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("abort_mw", MW, 0);
    check("abort_mab", MAB_out, 16'hC000);
    check("abort_ready", in_ready, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    model_addr = 16'hC000;
    model_wrap = 1'b0;

    for (int k = 0; k < 300; k++) begin
      ri.fmt = int'($urandom_range(3));
      ri.op = (ri.fmt == 1 || ri.fmt == 0) ? int'($urandom_range(15)) : int'($urandom_range(7));
      ri.src = int'($urandom_range(15));
      ri.dst = int'($urandom_range(15));
      ri.as_ = int'($urandom_range(3));
      ri.ad = int'($urandom_range(1));
      ri.bw = int'($urandom_range(1));
      ri.dext = int'($urandom_range(65535));
      ri.off = int'($urandom_range(1023));
      ri.sext = int'($urandom_range(65535));
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(6))
          0: ri.sext = 0;
          1: ri.sext = 1;
          2: ri.sext = 2;
          3: ri.sext = 4;
          4: ri.sext = 8;
          5: ri.sext = 65535;
          default: ri.sext = 255;
        endcase
        if ($urandom_range(1) == 1) begin
          ri.src = 0;
          ri.as_ = 3;
        end
      end
      if ($urandom_range(9) == 0)
        run_instr(ri, 1, ($urandom_range(3) == 0) ? 65532 : int'($urandom_range(32767)) * 2, 30, -1);
      else
        run_instr(ri, 0, 0, 30, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
